// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit core, with a watchdog that
// traps memory requests left unacknowledged for MEM_TIMEOUT cycles.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ir_op,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       mem_ack,
  input  logic       resume,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld_en,
  output logic       exec_en,
  output logic       rf_we,
  output logic       halted,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_HALT   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       op_q, op_nxt;
  logic             wd_trip;
  logic [9:0]       outs_d, outs_q;

  always_comb begin
    wd_trip = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ack;
    nxt     = cur;
    case (cur)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  if (mem_ack) nxt = S_LATCH;
                else if (wd_trip) nxt = S_ERROR;
      S_LATCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_LOAD, OP_STORE: nxt = S_MEM;
          4'hC:              nxt = flag_z ? S_BRANCH : S_FETCH;
          4'hD:              nxt = flag_n ? S_BRANCH : S_FETCH;
          4'hE:              nxt = S_BRANCH;
          4'hF:              nxt = S_HALT;
          default:           nxt = S_EXEC;
        endcase
      end
      S_EXEC, S_WB, S_BRANCH: nxt = S_FETCH;
      // MEM follows the opcode captured in DECODE, not the live IR
      S_MEM:    if (mem_ack) nxt = (op_q == OP_STORE) ? S_FETCH : S_WB;
                else if (wd_trip) nxt = S_ERROR;
      S_HALT:   if (resume) nxt = S_FETCH;
      S_ERROR:  nxt = S_ERROR;
      default:  nxt = S_RST;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if ((nxt == S_FETCH || nxt == S_MEM) && nxt != cur)
      cnt_nxt = '0;
    else if ((cur == S_FETCH || cur == S_MEM) && !mem_ack)
      cnt_nxt = cnt + 1'b1;
    op_nxt = (cur == S_DECODE) ? ir_op : op_q;
  end

  // Outputs are registered from the next state so they line up with `state`.
  always_comb begin
    outs_d = '0;
    case (nxt)
      S_FETCH:  outs_d = 10'b10_0000_0000;
      S_LATCH:  outs_d = 10'b00_0110_0000;
      S_EXEC:   outs_d = 10'b00_0000_1100;
      S_MEM:    outs_d = {1'b1, op_nxt == OP_STORE, 1'b1, 7'b000_1000};
      S_WB:     outs_d = 10'b00_0000_0100;
      S_BRANCH: outs_d = 10'b00_0001_1000;
      S_HALT:   outs_d = 10'b00_0000_0010;
      S_ERROR:  outs_d = 10'b00_0000_0011;
      default:  outs_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= S_RST;
      cnt    <= '0;
      op_q   <= '0;
      outs_q <= '0;
    end else begin
      cur    <= nxt;
      cnt    <= cnt_nxt;
      op_q   <= op_nxt;
      outs_q <= outs_d;
    end
  end

  assign {mem_req, mem_we, mem_addr_sel, ir_ld, pc_inc,
          pc_ld_en, exec_en, rf_we, halted, bus_err} = outs_q;
  assign state = cur;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected state/output vectors are
// queued as each cycle's stimulus is applied and compared one cycle later.
module tb_fetch_sequencer;

  localparam logic [3:0] RST = 4'd0, FETCH = 4'd1, LATCH = 4'd2, DECODE = 4'd3,
                         EXEC = 4'd4, MEM = 4'd5, WB = 4'd6, BRANCH = 4'd7,
                         HALT = 4'd8, ERROR = 4'd9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ir_op = '0;
  logic       flag_z = 1'b0, flag_n = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_ld, pc_inc, pc_ld_en;
  logic       exec_en, rf_we, halted, bus_err;
  logic [3:0] state;

  int   errors = 0;
  int   checks = 0;
  logic cur_store = 1'b0;
  logic [13:0] exp_q[$];
  logic [13:0] dut_vec;

  fetch_sequencer #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ir_op(ir_op), .flag_z(flag_z), .flag_n(flag_n),
    .mem_ack(mem_ack), .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_ld(ir_ld), .pc_inc(pc_inc),
    .pc_ld_en(pc_ld_en), .exec_en(exec_en), .rf_we(rf_we), .halted(halted),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, mem_req, mem_we, mem_addr_sel, ir_ld, pc_inc,
                    pc_ld_en, exec_en, rf_we, halted, bus_err};

  // Output table per state: req, we, addr_sel, ir_ld, pc_inc, pc_ld, exec, rf_we, halted, bus_err
  function automatic logic [13:0] exp_vec(input logic [3:0] st, input logic store);
    logic [9:0] v;
    case (st)
      FETCH:   v = 10'b1000000000;
      LATCH:   v = 10'b0001100000;
      EXEC:    v = 10'b0000001100;
      MEM:     v = {1'b1, store, 1'b1, 7'b0001000};
      WB:      v = 10'b0000000100;
      BRANCH:  v = 10'b0000011000;
      HALT:    v = 10'b0000000010;
      ERROR:   v = 10'b0000000011;
      default: v = 10'b0000000000;
    endcase
    return {st, v};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: apply inputs, queue the state expected after the
  // next rising edge, then compare at the following falling edge.
  task automatic step(input string tag, input logic [3:0] nst, input logic ack);
    mem_ack = ack;
    exp_q.push_back(exp_vec(nst, cur_store));
    @(negedge clk);
    check(tag, dut_vec, exp_q.pop_front());
  endtask

  // Runs one instruction starting and ending in FETCH.
  task automatic instr(input string tag, input logic [3:0] op, input logic z,
                       input logic n, input int fw, input int mw);
    ir_op = op; flag_z = z; flag_n = n;
    cur_store = (op == 4'h9);
    repeat (fw) step(tag, FETCH, 1'b0);
    step(tag, LATCH, 1'b1);
    if (op == 4'hF) resume = 1'b1;
    step(tag, DECODE, 1'b1);
    case (op)
      4'h8, 4'h9: begin
        step(tag, MEM, 1'b0);
        ir_op = {3'b100, ~op[0]};
        repeat (mw) step(tag, MEM, 1'b0);
        if (op == 4'h9) step(tag, FETCH, 1'b1);
        else begin
          step(tag, WB, 1'b1);
          step(tag, FETCH, 1'b1);
        end
      end
      4'hC, 4'hD: begin
        if ((op == 4'hC) ? z : n) begin
          step(tag, BRANCH, 1'b1);
          step(tag, FETCH, 1'b1);
        end else step(tag, FETCH, 1'b1);
      end
      4'hE: begin
        step(tag, BRANCH, 1'b1);
        step(tag, FETCH, 1'b1);
      end
      4'hF: begin
        step(tag, HALT, 1'b1);
        resume = 1'b0;
        repeat (20) step(tag, HALT, 1'b1);
        resume = 1'b1;
        step(tag, FETCH, 1'b0);
        resume = 1'b0;
      end
      default: begin
        step(tag, EXEC, 1'b1);
        step(tag, FETCH, 1'b1);
      end
    endcase
  endtask

  initial begin
    #12;
    check("reset_hold", dut_vec, 14'h0);
    @(negedge clk);
    reset = 1'b1;
    step("reset_exit", FETCH, 1'b0);

    resume = 1'b1;
    instr("alu_resume_ignored", 4'h1, 1'b0, 1'b0, 0, 0);
    resume = 1'b0;
    instr("alu_fetch_wait", 4'h3, 1'b0, 1'b0, 2, 0);
    instr("brz_taken", 4'hC, 1'b1, 1'b0, 0, 0);
    instr("brz_not_taken", 4'hC, 1'b0, 1'b1, 0, 0);
    instr("brn_taken", 4'hD, 1'b0, 1'b1, 0, 0);
    instr("brn_not_taken", 4'hD, 1'b1, 1'b0, 0, 0);
    instr("jmp", 4'hE, 1'b0, 1'b0, 0, 0);
    instr("load_wait3", 4'h8, 1'b0, 1'b0, 0, 3);
    instr("store_nowait", 4'h9, 1'b0, 1'b0, 0, 0);
    instr("store_wait2", 4'h9, 1'b0, 1'b0, 1, 2);
    instr("halt", 4'hF, 1'b0, 1'b0, 0, 0);
    instr("load_ack_last_cycle", 4'h8, 1'b0, 1'b0, 0, 15);
    instr("fetch_ack_last_cycle", 4'h2, 1'b0, 1'b0, 15, 0);

    ir_op = 4'h1;
    repeat (15) step("watchdog_wait", FETCH, 1'b0);
    step("watchdog_trip", ERROR, 1'b0);
    resume = 1'b1;
    repeat (3) step("error_hold", ERROR, 1'b1);
    resume = 1'b0;
    #2 reset = 1'b0;
    #1 check("error_async_reset", dut_vec, 14'h0);
    @(negedge clk);
    reset = 1'b1;
    step("error_reset_exit", FETCH, 1'b0);

    ir_op = 4'h8; cur_store = 1'b0;
    step("mid_mem_latch", LATCH, 1'b1);
    step("mid_mem_decode", DECODE, 1'b0);
    repeat (4) step("mid_mem_wait", MEM, 1'b0);
    #2 reset = 1'b0;
    #1 check("mid_mem_async_drop", dut_vec, 14'h0);
    @(negedge clk);
    check("mid_mem_reset_hold", dut_vec, 14'h0);
    reset = 1'b1;
    step("mid_mem_restart", FETCH, 1'b0);
    instr("post_reset_full_wait", 4'h1, 1'b0, 1'b0, 15, 0);

    check("scoreboard_drained", 14'(exp_q.size()), 14'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle control FSM that sequences the 16-bit CPU's fetch/decode/execute loop. Drives the program counter's load and increment enables, the instruction-register load, and the external-memory request handshake, and gates register-file writeback. It sits between the instruction register/flag outputs of the datapath and the program counter, memory interface and register file. A watchdog counter traps hung memory accesses.

## Interface
- MEM_TIMEOUT, 16: max cycles `mem_req` is held without `mem_ack` before trapping; 0 disables the watchdog.
- CNT_W, 5: watchdog counter width; must hold MEM_TIMEOUT-1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir_op  in  4  opcode field of the instruction register.
- flag_z  in  1  ALU zero flag.
- flag_n  in  1  ALU negative flag.
- mem_ack  in  1  memory access complete; sampled only while `mem_req`=1.
- resume  in  1  leave HALT; ignored in all other states.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier, valid with `mem_req`.
- mem_addr_sel  out  1  0 = address from PC, 1 = address from ALU output.
- ir_ld  out  1  load instruction register from memory data.
- pc_inc  out  1  PC increment enable.
- pc_ld_en  out  1  PC load enable; PC takes ALU output.
- exec_en  out  1  ALU/datapath execute strobe.
- rf_we  out  1  register-file write enable.
- halted  out  1  core stopped (HALT or ERROR).
- bus_err  out  1  watchdog trap occurred.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: RST=0, FETCH=1, LATCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, BRANCH=7, HALT=8, ERROR=9. Codes 10-15 are unreachable and recover to RST on the next clock.
- Outputs are Moore: decoded from `state` only.
  - RST: all outputs 0.
  - FETCH: `mem_req`=1, `mem_addr_sel`=0.
  - LATCH: `ir_ld`=1, `pc_inc`=1.
  - DECODE: none.
  - EXEC: `exec_en`=1, `rf_we`=1.
  - MEM: `mem_req`=1, `mem_addr_sel`=1, `exec_en`=1; `mem_we`=1 for STORE.
  - WB: `rf_we`=1.
  - BRANCH: `pc_ld_en`=1, `exec_en`=1.
  - HALT: `halted`=1.
  - ERROR: `halted`=1, `bus_err`=1.
- Transitions:
  - RST -> FETCH unconditionally.
  - FETCH -> LATCH on `mem_ack`.
  - LATCH -> DECODE.
  - DECODE branches on `ir_op`:
    - 4'h8 LOAD -> MEM; 4'h9 STORE -> MEM.
    - 4'hC BRZ -> BRANCH if `flag_z`, else FETCH.
    - 4'hD BRN -> BRANCH if `flag_n`, else FETCH.
    - 4'hE JMP -> BRANCH.
    - 4'hF HALT -> HALT.
    - Any other opcode -> EXEC.
  - EXEC -> FETCH.
  - MEM on `mem_ack`: -> WB for LOAD, -> FETCH for STORE.
  - WB -> FETCH; BRANCH -> FETCH.
  - HALT -> FETCH when `resume`=1.
  - ERROR is held until reset.
- DECODE latches `ir_op` and the LOAD/STORE decision into an internal register. MEM and WB use that latched copy, not live `ir_op`.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and increments each cycle in FETCH/MEM while `mem_ack`=0.
  - If counter = MEM_TIMEOUT-1 and `mem_ack`=0, next state is ERROR.
  - An ack on that final cycle wins, so `mem_req` is held at most MEM_TIMEOUT cycles.
- `pc_inc` and `pc_ld_en` are never asserted in the same cycle.

## Timing
- Reset: `reset`=0 forces state RST and clears the counter and latched opcode immediately, without waiting for a clock. All outputs are 0 while in RST. The first clock after release moves to FETCH.
- Reset asserted mid-access drops `mem_req` asynchronously. Any access in flight is abandoned.
- With zero-wait memory (`mem_ack`=1 in the first request cycle), cycles per instruction:
  - ALU: 4 (FETCH, LATCH, DECODE, EXEC).
  - Not-taken branch: 3.
  - Taken branch: 4.
  - STORE: 4.
  - LOAD: 5.
- Each memory wait cycle adds 1 cycle. `mem_req` stays high continuously until the ack.
- `ir_ld` and `pc_inc` are a single-cycle pulse in LATCH. PC holds PC+1 from DECODE onward, and `ir_op` is valid in DECODE.
- `mem_ack` while `mem_req`=0 is ignored.
- `resume` high on the same cycle HALT is entered does not apply. `resume` is first sampled in the cycle after `halted` rises.

## Test plan
- Reset, then ALU opcode 4'h1 with `mem_ack` tied high: state sequence 1,2,3,4,1. One `pc_inc` pulse and one `rf_we` pulse per 4 cycles.
- BRZ (4'hC): with `flag_z`=1, `pc_ld_en` pulses once in state 7, 4 cycles total. With `flag_z`=0, state returns to 1 after DECODE and `pc_ld_en` stays 0.
- LOAD (4'h8) with `mem_ack` delayed 3 cycles: `mem_req`=1 and `mem_addr_sel`=1 for 4 cycles, `mem_we`=0, then WB with `rf_we`=1. STORE (4'h9) shows `mem_we`=1 and returns straight to FETCH.
- HALT (4'hF): `halted`=1, and PC enables stay low for 20 cycles. A `resume` pulse returns to state 1 on the next cycle.
- MEM_TIMEOUT=16 with `mem_ack` held 0 in FETCH: after exactly 16 request cycles, state=9 and `bus_err`=1. It stays there until `reset`=0, which returns all outputs to 0.
- `reset` pulsed low mid-MEM wait: `mem_req` falls without a clock edge. After release the sequence restarts at FETCH with the counter cleared.
